// File: rtl/dht11_pkg.sv
// DHT11 controller shared types and constants.
// FSM states, frame width, default timing in microseconds.
package dht11_pkg;

  localparam int FRAME_W           = 40;
  localparam int US_W              = 16;
  localparam int DEF_CLK_FREQ      = 100_000_000;
  localparam int DEF_START_LOW_US  = 18000;
  localparam int DEF_HOST_HIGH_US  = 20;
  localparam int DEF_BIT_THRESH_US = 40;
  localparam int DEF_TIMEOUT_US    = 255;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SYNC_L,
    S_SYNC_H,
    S_SYNC_END,
    S_DATA_L,
    S_DATA_H,
    S_STOP,
    S_DONE
  } state_t;

  // Four payload bytes summed mod 256 must equal the trailing byte.
  function automatic logic csum_ok(input logic [FRAME_W-1:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht11_tick_gen.sv
// Free-running 1 us timebase.
// Emits a one-clock tick each time the divider wraps.
module dht11_tick_gen
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_FREQ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire master: start pulse, sync check,
// 40-bit capture by high-pulse width, checksum report.
module dht11_controller
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ      = DEF_CLK_FREQ,
  parameter int START_LOW_US  = DEF_START_LOW_US,
  parameter int HOST_HIGH_US  = DEF_HOST_HIGH_US,
  parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               tick,
  output logic [FRAME_W-1:0] dht_data_out,
  output logic               valid,
  output logic               done,
  inout  wire                dht_io
);

  localparam logic [US_W-1:0] LOW_END  = US_W'(START_LOW_US - 1);
  localparam logic [US_W-1:0] HIGH_END = US_W'(HOST_HIGH_US - 1);
  localparam logic [US_W-1:0] TMO_END  = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0] THRESH   = US_W'(BIT_THRESH_US);
  localparam logic [5:0]      LAST_BIT = 6'(FRAME_W - 1);

  state_t state, nxt;

  logic [US_W-1:0]    us_cnt;
  logic [5:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic io_s1, io_s2, io_d, start_d;
  logic rise, fall, start_rise, tmo, wait_st;
  logic bus_oe, bus_drv;
  logic sh_en, bit_clr, bit_inc, latch, abort;

  dht11_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign dht_io = bus_oe ? bus_drv : 1'bz;

  // Synchronizers idle high to match the pulled-up bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_s1   <= 1'b1;
      io_s2   <= 1'b1;
      io_d    <= 1'b1;
      start_d <= 1'b0;
    end else begin
      io_s1   <= dht_io;
      io_s2   <= io_s1;
      io_d    <= io_s2;
      start_d <= start;
    end
  end

  assign rise       = io_s2 & ~io_d;
  assign fall       = ~io_s2 & io_d;
  assign start_rise = start & ~start_d;
  assign tmo        = tick && (us_cnt == TMO_END);
  assign wait_st    = state inside {S_SYNC_L, S_SYNC_H,
                      S_SYNC_END, S_DATA_L, S_DATA_H};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    bus_oe  = 1'b0;
    bus_drv = 1'b0;
    sh_en   = 1'b0;
    bit_clr = 1'b0;
    bit_inc = 1'b0;
    latch   = 1'b0;
    abort   = 1'b0;
    unique case (state)
      S_IDLE:
        if (start_rise) nxt = S_START;
      S_START: begin
        bus_oe = 1'b1;
        if (tick && us_cnt == LOW_END) nxt = S_WAIT;
      end
      S_WAIT: begin
        bus_oe  = 1'b1;
        bus_drv = 1'b1;
        if (tick && us_cnt == HIGH_END) nxt = S_SYNC_L;
      end
      S_SYNC_L:
        if (fall) nxt = S_SYNC_H;
      S_SYNC_H:
        if (rise) nxt = S_SYNC_END;
      S_SYNC_END:
        if (fall) begin
          bit_clr = 1'b1;
          nxt     = S_DATA_L;
        end
      S_DATA_L:
        if (rise) nxt = S_DATA_H;
      S_DATA_H:
        if (fall) begin
          sh_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            nxt = S_STOP;
          end else begin
            bit_inc = 1'b1;
            nxt     = S_DATA_L;
          end
        end
      // Frame is complete here, so a missing release still reports it.
      S_STOP:
        if (rise || tmo) begin
          latch = 1'b1;
          nxt   = S_DONE;
        end
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
    if (wait_st && tmo) begin
      nxt     = S_IDLE;
      abort   = 1'b1;
      sh_en   = 1'b0;
      bit_clr = 1'b0;
      bit_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (nxt != state)
        us_cnt <= '0;
      else if (tick && state != S_IDLE)
        us_cnt <= us_cnt + 1'b1;
      if (bit_clr)
        bit_cnt <= '0;
      else if (bit_inc)
        bit_cnt <= bit_cnt + 1'b1;
      if (sh_en)
        shreg <= {shreg[FRAME_W-2:0], (us_cnt > THRESH)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dht_data_out <= '0;
      valid        <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= latch | abort;
      if (latch) begin
        dht_data_out <= shreg;
        valid        <= csum_ok(shreg);
      end else if (abort || (state == S_IDLE && nxt == S_START)) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht11_controller.sv
// Directed bench for dht11_controller with a sensor model
// on the pulled-up bus and a frame scoreboard.
module tb_dht11_controller;
  import dht11_pkg::*;

  localparam int CLK_HZ = 2_000_000;
  localparam int LOW_US = 200;
  localparam int HI_US  = 20;
  localparam int THR_US = 40;
  localparam int TMO_US = 255;
  localparam int US     = 1000;

  typedef struct packed {
    logic [39:0] d;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sens_low = 1'b0;
  logic        tick, valid, done;
  logic [39:0] dout;
  wire         dht_io;

  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   done_exp = 0;
  exp_t q[$];

  assign dht_io = sens_low ? 1'b0 : 1'bz;
  pullup (dht_io);

  dht11_controller #(
    .CLK_FREQ     (CLK_HZ),
    .START_LOW_US (LOW_US),
    .HOST_HIGH_US (HI_US),
    .BIT_THRESH_US(THR_US),
    .TIMEOUT_US   (TMO_US)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .tick        (tick),
    .dht_data_out(dout),
    .valid       (valid),
    .done        (done),
    .dht_io      (dht_io)
  );

  always #250 clk = ~clk;

  always @(negedge clk)
    if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_line(input logic lvl, input int max_us,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_us * 4; i++) begin
      if (dht_io === lvl) begin
        ok = 1'b1;
        break;
      end
      #(US / 4);
    end
  endtask

  task automatic wait_release(input int max_us, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_us * 4; i++) begin
      if (dut.bus_oe === 1'b0) begin
        ok = 1'b1;
        break;
      end
      #(US / 4);
    end
  endtask

  task automatic wait_done(input string tag, input int max_us,
                           output realtime t);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 2 * max_us; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    t = $realtime;
    chk({tag, "_done"}, seen, 1);
    done_exp++;
    e = q.pop_front();
    chk({tag, "_data"}, dout, e.d);
    chk({tag, "_valid"}, valid, e.v);
    @(negedge clk);
    #1;
    chk({tag, "_pulse1"}, done, 0);
    chk({tag, "_ndone"}, done_cnt, done_exp);
  endtask

  task automatic host_start(input string tag);
    bit ok;
    @(negedge clk);
    start = 1'b1;
    wait_line(1'b0, 10, ok);
    chk({tag, "_hlow"}, ok, 1);
    #(5 * US);
    start = 1'b0;
    wait_line(1'b1, LOW_US + 10, ok);
    chk({tag, "_hhigh"}, ok, 1);
    #((HI_US + 30) * US + US / 8);
  endtask

  task automatic send(input logic [39:0] f, input int w0, input int w1,
                      input int n, input bit fin, output realtime t_last);
    sens_low = 1'b1;
    #(80 * US);
    sens_low = 1'b0;
    t_last = $realtime;
    #(80 * US);
    for (int i = 0; i < n; i++) begin
      sens_low = 1'b1;
      #(50 * US);
      sens_low = 1'b0;
      t_last = $realtime;
      if (f[39-i]) #(w1 * US);
      else         #(w0 * US);
    end
    if (fin) begin
      sens_low = 1'b1;
      #(50 * US);
      sens_low = 1'b0;
    end
  endtask

  task automatic do_frame(input string tag, input logic [39:0] f,
                          input int w0, input int w1, input logic v);
    realtime t;
    q.push_back({f, v});
    host_start(tag);
    send(f, w0, w1, 40, 1'b1, t);
    wait_done(tag, 20, t);
  endtask

  initial begin
    realtime t0, t1, t2, td;
    real     el;
    bit      ok;
    int      ticks;

    repeat (4) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", dout, 0);
    chk("rst_oe", dut.bus_oe, 0);
    chk("rst_line", dht_io, 1);
    chk("rst_state", dut.state, S_IDLE);
    rst = 1'b0;

    ticks = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
    end
    chk("tick_rate", ticks, 20);

    // Host pulse with a silent sensor, ending in a SYNC_L timeout.
    q.push_back({40'h0, 1'b0});
    @(negedge clk);
    start = 1'b1;
    wait_line(1'b0, 10, ok);
    t0 = $realtime;
    chk("hs_fall", ok, 1);
    #(49 * US);
    start = 1'b0;
    wait_line(1'b1, LOW_US + 10, ok);
    t1 = $realtime;
    chk("hs_rise", ok, 1);
    el = (t1 - t0) / US;
    chk("hs_low_us", (el >= LOW_US - 1) && (el <= LOW_US + 1), 1);
    wait_release(HI_US + 10, ok);
    t2 = $realtime;
    chk("hs_release", ok, 1);
    el = (t2 - t1) / US;
    chk("hs_high_us", (el >= HI_US - 1) && (el <= HI_US + 1), 1);
    chk("hs_line_idle", dht_io, 1);
    wait_done("hs_tmo", TMO_US + 30, td);
    el = (td - t2) / US;
    chk("hs_tmo_us", (el >= TMO_US - 2) && (el <= TMO_US + 2), 1);

    do_frame("bad", 40'hAA0FC4007F, 29, 68, 1'b0);
    do_frame("good", 40'h320019004B, 29, 68, 1'b1);
    do_frame("thr", 40'h5A3C810017, 38, 42, 1'b1);

    // Sensor goes quiet high after 20 bits.
    q.push_back({40'h5A3C810017, 1'b0});
    host_start("stk");
    send(40'h320019004B, 29, 68, 20, 1'b0, t0);
    wait_done("stk", TMO_US + 20, td);
    el = (td - t0) / US;
    chk("stk_tmo_us", (el >= TMO_US - 2) && (el <= TMO_US + 3), 1);
    chk("stk_idle", dut.state, S_IDLE);
    chk("stk_oe", dut.bus_oe, 0);

    do_frame("again", 40'h320019004B, 29, 68, 1'b1);

    // Reset in the middle of the host low pulse.
    @(negedge clk);
    start = 1'b1;
    wait_line(1'b0, 10, ok);
    chk("rm_low", ok, 1);
    start = 1'b0;
    #(20 * US);
    chk("rm_valid_clr", valid, 0);
    chk("rm_in_start", dut.state, S_START);
    @(negedge clk);
    #50;
    rst = 1'b1;
    #1;
    chk("rm_oe", dut.bus_oe, 0);
    chk("rm_line", dht_io, 1);
    chk("rm_state", dut.state, S_IDLE);
    chk("rm_data", dout, 0);
    chk("rm_valid", valid, 0);
    chk("rm_done", done, 0);
    chk("rm_tick", tick, 0);
    #(2 * US);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rm_ndone", done_cnt, done_exp);
    chk("rm_idle", dut.state, S_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dht11_controller.md
Name: dht11_controller

Overview:
- Single-wire DHT11 humidity/temperature sensor master.
- On a start request it:
  - issues the host start pulse on the bidirectional line;
  - checks the sensor's 80/80 µs response;
  - captures 40 data bits by measuring high-pulse widths;
  - reports the 40-bit frame with a checksum-valid flag and a completion pulse.
- Sits between the system-clock logic (button/FSM) and the top-level inout pad.
- Contains its own 1 µs timebase, which is exported.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; tick period = CLK_FREQ/1_000_000 clocks.
- START_LOW_US, 18000, host low-drive duration of the start pulse (µs).
- HOST_HIGH_US, 20, host active-high drive after the start pulse, before release (µs).
- BIT_THRESH_US, 40, high-pulse width above which a bit is 1 (µs).
- TIMEOUT_US, 255, maximum time allowed in any wait-for-edge state (µs).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  measurement request; rising edge is detected, so level width is irrelevant.
- tick  output  1  one-clock pulse every 1 µs (internal timebase, free-running).
- dht_data_out  output  40  last frame, MSB = first received bit: [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum.
- valid  output  1  checksum of last frame correct.
- done  output  1  one-clock pulse when a transaction ends (success, checksum fail or timeout).
- dht_io  inout  1  sensor bus. Driven only when the output enable is set, otherwise high-Z (external pull-up).

Behaviour:
- Reset values:
  - all counters and state cleared to IDLE;
  - dht_data_out=0, valid=0, done=0, tick=0;
  - dht_io released (Z).
- Timebase: the counter wraps at CLK_FREQ/1e6-1 and tick pulses on wrap. All µs counts advance only on tick.
- dht_io input path:
  - passes through a 2-FF synchronizer;
  - a registered copy gives rise/fall edge strobes.
- FSM states and transitions:
  - IDLE: bus released. On a start rising edge → START. valid is cleared on leaving IDLE.
  - START: drive 0 for START_LOW_US → WAIT.
  - WAIT: drive 1 for HOST_HIGH_US, then release → SYNC_L.
  - SYNC_L: await a falling edge (sensor low, about 20–40 µs after the host high) → SYNC_H.
  - SYNC_H: await the rising edge ending the 80 µs low → SYNC_END.
  - SYNC_END: await the falling edge ending the 80 µs high → DATA_L. Bit counter = 0.
  - DATA_L: await the rising edge ending the 50 µs low; clear the µs width counter → DATA_H.
  - DATA_H: count µs while high. On a falling edge:
    - shift in bit = (width > BIT_THRESH_US);
    - if bit counter = 39 → STOP, else increment and → DATA_L.
  - STOP: await the rising edge or release after the sensor's final 50 µs low, or TIMEOUT → DONE.
  - DONE: for one clock:
    - latch shift register into dht_data_out;
    - valid = (sum of bytes [39:8] mod 256 == [7:0]);
    - done=1;
    - → IDLE.
- Timeout: in SYNC_L, SYNC_H, SYNC_END, DATA_L and DATA_H, if the per-state µs counter reaches TIMEOUT_US:
  - → IDLE, bus released;
  - done=1 for one clock;
  - valid=0;
  - dht_data_out unchanged.
- The per-state µs counter clears on every state change.
- start during a transaction is ignored.
- Asynchronous reset mid-transaction immediately releases the bus and returns to IDLE.
- Latency from the last falling data edge to done: at most 50 µs + 3 clocks.

Decomposition:
- Shared package dht11_pkg:
  - FSM state enum;
  - frame width (40);
  - default timing constants in µs.
- One sub-module is natural: dht11_tick_gen (parameter CLK_FREQ, outputs 1 µs tick), instantiated inside dht11_controller.

Test Plan:
- Host start pulse:
  - stimulus: start held high for 50 µs after reset, sensor model passive;
  - required: dht_io low for 18000 µs ±1, driven high 20 µs, then Z;
  - required: timeout done pulse about 255 µs later, valid=0.
- Full frame, bad checksum:
  - stimulus: sensor answers 30 µs after the high, with 80 µs low / 80 µs high, then bits 0x AA 0F C4 00 7F (50 µs low; high 29 µs for 0, 68 µs for 1), then 50 µs low and release;
  - required: dht_data_out=0xAA0FC4007F, valid=0 (sum 0x7D≠0x7F), one done pulse.
- Full frame, good checksum:
  - stimulus: same sequence with data 0x32 00 19 00 4B;
  - required: dht_data_out=0x320019004B, valid=1, done for exactly 1 clock.
- Bit threshold:
  - stimulus: high widths of 38 µs and 42 µs on consecutive bits;
  - required: decoded as 0 and 1 respectively.
- Stuck-high sensor:
  - stimulus: sensor stops after 20 bits (line pulled high);
  - required: done after ≤TIMEOUT_US+1 µs, valid=0, dht_data_out keeps its previous value, FSM back in IDLE, a new start works.
- Reset mid-transaction:
  - stimulus: rst asserted during START;
  - required: dht_io released the same cycle, all outputs 0, state IDLE.
